ro_heater_seq: RTL and testbench

- Multi-channel, self-timed ring-oscillator heater sequencer; next generation of the per-heater strobe-driven heater controller.
- Plays a programmable bit pattern onto a parametrised set of heater enables, MSB first.
- Each bit's timing comes from an internal half-period counter, not external strobes.
- Supports Manchester, NRZ and constant-on modes, an arbitrary per-heater channel mask, repeat counts, abort, and done/status reporting.
- Sits between the kernel control registers and the heater RO arrays; the top level wires heat_en[i] to heater instance i.

---
 rtl/ro_heater_seq.sv | 177 +++++++++++++++++
 tb/tb_ro_heater_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_heater_seq.sv
// Self-timed heater pattern sequencer: plays a latched bit pattern MSB first onto masked
// heater enables, two half-bits per bit, in Manchester, NRZ or constant-on mode.
module ro_heater_seq #(
  parameter int MAX_BIT_SIZE = 256,
  parameter int NUM_HEATERS  = 8,
  parameter int CNT_W        = 32
) (
  input  logic                          ro_clk,
  input  logic                          rst_n,
  // Handshake: a config is taken on a rising edge where cfg_valid && cfg_ready && !abort.
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [MAX_BIT_SIZE-1:0]       cfg_data,
  input  logic [$clog2(MAX_BIT_SIZE):0] cfg_len,
  input  logic [NUM_HEATERS-1:0]        cfg_mask,
  input  logic [CNT_W-1:0]              cfg_half_period,
  input  logic [15:0]                   cfg_repeat,
  input  logic [1:0]                    cfg_mode,
  input  logic                          abort,
  output logic [NUM_HEATERS-1:0]        heat_en,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [$clog2(MAX_BIT_SIZE):0] bit_index,
  output logic [CNT_W-1:0]              pass_count,
  output logic [1:0]                    dbg_state
);
  localparam int LW = $clog2(MAX_BIT_SIZE) + 1;
  localparam int IW = $clog2(MAX_BIT_SIZE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HALF1 = 2'd1, S_HALF2 = 2'd2, S_DONE = 2'd3} state_t;

  state_t                  state_q, state_d;
  logic [MAX_BIT_SIZE-1:0] data_q;
  logic [LW-1:0]           len_q;
  logic [NUM_HEATERS-1:0]  mask_q;
  logic [CNT_W-1:0]        hm1_q;
  logic [15:0]             rep_q;
  logic [1:0]              mode_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]        pass_q, pass_d;
  logic [NUM_HEATERS-1:0]  heat_q, heat_d;
  logic                    aborted_q, aborted_d;
  logic                    load;

  logic [1:0]              mode_in;
  logic [CNT_W-1:0]        hm1_in;
  logic [LW-1:0]           idx_inc, idx_wrap;
  logic [CNT_W-1:0]        pass_inc;
  logic                    b_first, b_cur, b_next;

  function automatic logic half1_bit(input logic [1:0] m, input logic b);
    return (m == 2'd2) ? 1'b1 : b;
  endfunction

  function automatic logic half2_bit(input logic [1:0] m, input logic b);
    case (m)
      2'd0:    return ~b;
      2'd1:    return b;
      default: return 1'b1;
    endcase
  endfunction

  // Reserved mode folds onto Manchester; a zero half-period behaves as one cycle.
  assign mode_in  = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
  assign hm1_in   = (cfg_half_period == '0) ? '0 : cfg_half_period - CNT_W'(1);
  assign idx_inc  = idx_q + LW'(1);
  assign idx_wrap = (idx_inc == len_q) ? '0 : idx_inc;
  assign pass_inc = (pass_q == '1) ? pass_q : pass_q + CNT_W'(1);
  assign b_first  = cfg_data[IW'(cfg_len - LW'(1))];
  assign b_cur    = data_q[IW'(len_q - LW'(1) - idx_q)];
  assign b_next   = data_q[IW'(len_q - LW'(1) - idx_wrap)];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    heat_d    = '0;
    aborted_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && !abort) begin
          load  = 1'b1;
          idx_d = '0;
          pass_d = '0;
          if (cfg_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HALF1;
            cnt_d   = hm1_in;
            heat_d  = cfg_mask & {NUM_HEATERS{half1_bit(mode_in, b_first)}};
          end
        end
      end
      S_HALF1: begin
        if (cnt_q == '0) begin
          state_d = S_HALF2;
          cnt_d   = hm1_q;
          heat_d  = mask_q & {NUM_HEATERS{half2_bit(mode_q, b_cur)}};
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          heat_d = heat_q;
        end
      end
      S_HALF2: begin
        if (cnt_q == '0) begin
          idx_d = idx_wrap;
          if (idx_inc == len_q) pass_d = pass_inc;
          if ((idx_inc == len_q) && (rep_q != '0) && (pass_inc == CNT_W'(rep_q))) begin
            state_d = S_DONE;
          end else begin
            state_d = S_HALF1;
            cnt_d   = hm1_q;
            heat_d  = mask_q & {NUM_HEATERS{half1_bit(mode_q, b_next)}};
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          heat_d = heat_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any half transition, freezing the progress counters.
    if (abort && (state_q == S_HALF1 || state_q == S_HALF2)) begin
      state_d   = S_IDLE;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      pass_d    = pass_q;
      heat_d    = '0;
      aborted_d = 1'b1;
    end
  end

  always_ff @(posedge ro_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      heat_q    <= '0;
      aborted_q <= 1'b0;
      data_q    <= '0;
      len_q     <= '0;
      mask_q    <= '0;
      hm1_q     <= '0;
      rep_q     <= '0;
      mode_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      heat_q    <= heat_d;
      aborted_q <= aborted_d;
      if (load) begin
        data_q <= cfg_data;
        len_q  <= cfg_len;
        mask_q <= cfg_mask;
        hm1_q  <= hm1_in;
        rep_q  <= cfg_repeat;
        mode_q <= mode_in;
      end
    end
  end

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q == S_HALF1) || (state_q == S_HALF2);
  assign done       = (state_q == S_DONE);
  assign aborted    = aborted_q;
  assign heat_en    = heat_q;
  assign bit_index  = idx_q;
  assign pass_count = pass_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_ro_heater_seq.sv
// Directed bench for ro_heater_seq: a table of complete runs checked cycle by cycle, plus
// hand sequences for zero length, full length, infinite mode, abort, handshake and reset.
module tb_ro_heater_seq;
  logic         ro_clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [255:0] cfg_data;
  logic [8:0]   cfg_len;
  logic [7:0]   cfg_mask;
  logic [31:0]  cfg_half_period;
  logic [15:0]  cfg_repeat;
  logic [1:0]   cfg_mode;
  logic         abort;
  logic [7:0]   heat_en;
  logic         busy, done, aborted;
  logic [8:0]   bit_index;
  logic [31:0]  pass_count;
  logic [1:0]   dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]   mode;
    logic [8:0]   len;
    logic [255:0] data;
    logic [7:0]   mask;
    logic [31:0]  half;
    logic [15:0]  rep;
    logic [7:0]   heff;
    logic [7:0]   nh;
    logic [95:0]  halves;
    logic [31:0]  exp_pass;
  } vec_t;

  vec_t vecs[5];

  ro_heater_seq dut (
    .ro_clk(ro_clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_len(cfg_len), .cfg_mask(cfg_mask),
    .cfg_half_period(cfg_half_period), .cfg_repeat(cfg_repeat), .cfg_mode(cfg_mode),
    .abort(abort), .heat_en(heat_en), .busy(busy), .done(done), .aborted(aborted),
    .bit_index(bit_index), .pass_count(pass_count), .dbg_state(dbg_state)
  );

  always #5 ro_clk = ~ro_clk;

  task automatic step();
    @(posedge ro_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [8:0] l, input logic [255:0] d,
                         input logic [7:0] mk, input logic [31:0] h, input logic [15:0] r);
    cfg_mode = m; cfg_len = l; cfg_data = d; cfg_mask = mk; cfg_half_period = h; cfg_repeat = r;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   k;
    v = vecs[i];
    set_cfg(v.mode, v.len, v.data, v.mask, v.half, v.rep);
    chk("ready_before", cfg_ready, 1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("ready_in_run", cfg_ready, 0);
    for (k = 0; k < int'(v.nh); k++) begin
      for (int c = 0; c < int'(v.heff); c++) begin
        chk("heat_en", heat_en, v.halves[95-8*k -: 8]);
        chk("busy", busy, 1);
        chk("done_low", done, 0);
        chk("bit_index", bit_index, (k / 2) % int'(v.len));
        chk("pass_mid", pass_count, k / (2 * int'(v.len)));
        step();
      end
    end
    chk("done_pulse", done, 1);
    chk("done_heat", heat_en, 0);
    chk("done_busy", busy, 0);
    chk("done_aborted", aborted, 0);
    step();
    chk("done_clear", done, 0);
    chk("idle_ready", cfg_ready, 1);
    chk("final_pass", pass_count, v.exp_pass);
    chk("final_idx", bit_index, 0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0;
    set_cfg(2'd0, 9'd0, '0, 8'h00, 32'd0, 16'd0);

    vecs[0] = '{mode: 2'd0, len: 9'd4, data: 256'b1010, mask: 8'h0F, half: 32'd3, rep: 16'd1,
                heff: 8'd3, nh: 8'd8,
                halves: {8'h0F, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h0F, 32'h0},
                exp_pass: 32'd1};
    vecs[1] = '{mode: 2'd1, len: 9'd2, data: 256'b10, mask: 8'hA5, half: 32'd1, rep: 16'd3,
                heff: 8'd1, nh: 8'd12, halves: {3{32'hA5A5_0000}}, exp_pass: 32'd3};
    vecs[2] = '{mode: 2'd0, len: 9'd2, data: 256'b01, mask: 8'h3C, half: 32'd0, rep: 16'd1,
                heff: 8'd1, nh: 8'd4, halves: {8'h00, 8'h3C, 8'h3C, 8'h00, 64'h0},
                exp_pass: 32'd1};
    vecs[3] = '{mode: 2'd3, len: 9'd3, data: 256'b110, mask: 8'hFF, half: 32'd2, rep: 16'd1,
                heff: 8'd2, nh: 8'd6, halves: {8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 48'h0},
                exp_pass: 32'd1};
    vecs[4] = '{mode: 2'd2, len: 9'd2, data: 256'b00, mask: 8'h81, half: 32'd1, rep: 16'd2,
                heff: 8'd1, nh: 8'd8, halves: {{8{8'h81}}, 32'h0}, exp_pass: 32'd2};

    // Reset state
    step(); step();
    rst_n = 1'b1;
    chk("rst_heat", heat_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_idx", bit_index, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_state", dbg_state, 0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // Zero-length pattern: done the cycle after acceptance; abort during DONE is ignored
    set_cfg(2'd0, 9'd0, '1, 8'hFF, 32'd2, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_heat", heat_en, 0);
    chk("len0_busy", busy, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("len0_no_abort", aborted, 0);
    chk("len0_idle", cfg_ready, 1);
    chk("len0_heat2", heat_en, 0);

    // Full-length pattern: MSB shows first, then abort stops it
    set_cfg(2'd1, 9'd256, {1'b1, 255'b0}, 8'h5A, 32'd2, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("len256_msb", heat_en, 8'h5A);
      step();
    end
    chk("len256_bit1", heat_en, 8'h00);
    chk("len256_idx", bit_index, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_heat", heat_en, 0);
    chk("abort_pulse", aborted, 1);
    chk("abort_done", done, 0);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_busy", busy, 0);
    step();
    chk("abort_clear", aborted, 0);

    // Infinite constant-on: pass every 2*H*len = 12 cycles; a mid-run config is ignored
    set_cfg(2'd2, 9'd3, 256'b0, 8'hFF, 32'd2, 16'd0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("inf_ready", cfg_ready, 0);
    set_cfg(2'd0, 9'd1, 256'b0, 8'h00, 32'd1, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int c = 1; c < 24; c++) begin
      chk("inf_heat", heat_en, 8'hFF);
      chk("inf_pass", pass_count, c / 12);
      step();
    end
    chk("inf_pass2", pass_count, 2);
    chk("inf_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("inf_abort_heat", heat_en, 0);
    chk("inf_abort_pulse", aborted, 1);
    chk("inf_abort_done", done, 0);
    chk("inf_abort_ready", cfg_ready, 1);
    chk("inf_abort_pass", pass_count, 2);

    // cfg_valid together with abort in IDLE is not accepted
    set_cfg(2'd1, 9'd1, 256'b1, 8'hFF, 32'd1, 16'd1);
    cfg_valid = 1'b1; abort = 1'b1;
    step();
    cfg_valid = 1'b0; abort = 1'b0;
    chk("va_busy", busy, 0);
    chk("va_state", dbg_state, 0);
    chk("va_heat", heat_en, 0);

    // New config held through DONE is taken on the following IDLE cycle
    set_cfg(2'd1, 9'd1, 256'b1, 8'h01, 32'd1, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step(); step();
    chk("b2b_done", done, 1);
    set_cfg(2'd1, 9'd1, 256'b1, 8'h02, 32'd1, 16'd1);
    cfg_valid = 1'b1;
    step();
    chk("b2b_idle_ready", cfg_ready, 1);
    chk("b2b_idle_heat", heat_en, 0);
    step();
    cfg_valid = 1'b0;
    chk("b2b_heat", heat_en, 8'h02);
    chk("b2b_busy", busy, 1);
    step();
    chk("b2b_heat2", heat_en, 8'h02);
    step();
    chk("b2b_done2", done, 1);
    step();

    // Reset during HALF2, then a normal run from bit 0
    set_cfg(2'd0, 9'd2, 256'b11, 8'hFF, 32'd2, 16'd1);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    step(); step();
    chk("pre_rst_half2", dbg_state, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_heat", heat_en, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_aborted", aborted, 0);
    chk("mrst_idx", bit_index, 0);
    chk("mrst_pass", pass_count, 0);
    chk("mrst_state", dbg_state, 0);
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
